// File: rtl/conv_window_mac_if.sv
// rtl/conv_window_mac_if.sv - controller-side request/response handshake bundle
//
// Carries one request and its response between the convolution controller
// (master) and the window MAC (slave).
//   en         : request, held high by the controller until ack is seen
//   base_addrA : kernel select
//   base_addrB : image address of the window top-left pixel
//   ack        : result valid / request complete
//   out_pix    : signed result pixel
//   busy       : responder is working on (or returning) a request
interface conv_window_mac_if #(
  parameter int ADDR_A_W = 4,
  parameter int ADDR_B_W = 13,
  parameter int ACC_W    = 32
);
  logic                en;
  logic [ADDR_A_W-1:0] base_addrA;
  logic [ADDR_B_W-1:0] base_addrB;
  logic                ack;
  logic [ACC_W-1:0]    out_pix;
  logic                busy;

  modport master (
    output en, base_addrA, base_addrB,
    input  ack, out_pix, busy
  );

  modport slave (
    input  en, base_addrA, base_addrB,
    output ack, out_pix, busy
  );
endinterface

// File: rtl/conv_window_mac.sv
// rtl/conv_window_mac.sv - KxK signed window dot product behind a 4-phase handshake
//
// Accepts a request from the convolution controller, streams K*K kernel and
// image words out of synchronous memories, accumulates their signed products
// and returns the pixel with a 4-phase en/ack handshake.
//
// Optional feature macro: CONV_RELU_EN (clamps the returned pixel at zero).
//
// Ports:
//   clk, rst_n : clock (rising edge), asynchronous active-low reset
//   ctrl       : controller handshake (en, base_addrA, base_addrB, ack, out_pix, busy)
//   krn_rd     : kernel memory read strobe
//   krn_addr   : kernel memory address (kernel_select*K*K + tap)
//   krn_data   : kernel word, valid one cycle after krn_rd
//   img_rd     : image memory read strobe
//   img_addr   : image memory address (wraps modulo 2^ADDR_B_W)
//   img_data   : image word, valid one cycle after img_rd
module conv_window_mac #(
  parameter int K          = 3,
  parameter int IMG_WIDTH  = 64,
  parameter int DATA_W     = 16,
  parameter int ACC_W      = 32,
  parameter int ADDR_A_W   = 4,
  parameter int ADDR_B_W   = 13,
  parameter int KRN_ADDR_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  conv_window_mac_if.slave         ctrl,
  output logic                     krn_rd,
  output logic [KRN_ADDR_W-1:0]    krn_addr,
  input  logic signed [DATA_W-1:0] krn_data,
  output logic                     img_rd,
  output logic [ADDR_B_W-1:0]      img_addr,
  input  logic signed [DATA_W-1:0] img_data
);

  localparam int TAPS  = K * K;
  localparam int TAP_W = $clog2(TAPS + 1);
  localparam int COL_W = $clog2(K + 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, ACK} state_t;

  state_t state, state_next;

  logic [TAP_W-1:0]          tap;
  logic [COL_W-1:0]          col;
  logic [ADDR_B_W-1:0]       row_base;   // image address of column 0 in the current row
  logic                      data_vld;   // memory data on the bus belongs to this request
  logic signed [ACC_W-1:0]   acc;
  logic signed [ACC_W-1:0]   acc_sum;
  logic signed [ACC_W-1:0]   pix_val;
  logic signed [2*DATA_W-1:0] prod;
  logic                      ack_q;
  logic                      busy_q;
  logic [ACC_W-1:0]          out_pix_q;
  logic                      last_tap;
  logic                      col_last;

  assign last_tap = (tap == TAP_W'(TAPS - 1));
  assign col_last = (col == COL_W'(K - 1));

  assign prod    = krn_data * img_data;
  assign acc_sum = acc + ACC_W'(prod);

`ifdef CONV_RELU_EN
  assign pix_val = acc_sum[ACC_W-1] ? '0 : acc_sum;
`else
  assign pix_val = acc_sum;
`endif

  assign ctrl.ack     = ack_q;
  assign ctrl.busy    = busy_q;
  assign ctrl.out_pix = out_pix_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (ctrl.en)  state_next = FETCH;
      FETCH:   if (last_tap) state_next = DRAIN;
      DRAIN:                 state_next = ACK;
      ACK:     if (!ctrl.en) state_next = IDLE;
      default:               state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tap       <= '0;
      col       <= '0;
      row_base  <= '0;
      data_vld  <= 1'b0;
      acc       <= '0;
      ack_q     <= 1'b0;
      busy_q    <= 1'b0;
      out_pix_q <= '0;
      krn_rd    <= 1'b0;
      krn_addr  <= '0;
      img_rd    <= 1'b0;
      img_addr  <= '0;
    end else begin
      // Memories answer one cycle after the strobe, so the product on the
      // bus is valid exactly in the cycle after a read was issued.
      data_vld <= krn_rd;
      if (data_vld) acc <= acc_sum;

      case (state)
        IDLE: begin
          if (ctrl.en) begin
            busy_q   <= 1'b1;
            tap      <= '0;
            col      <= '0;
            acc      <= '0;
            row_base <= ctrl.base_addrB;
            krn_rd   <= 1'b1;
            img_rd   <= 1'b1;
            krn_addr <= KRN_ADDR_W'(ctrl.base_addrA) * KRN_ADDR_W'(TAPS);
            img_addr <= ctrl.base_addrB;
          end
        end
        FETCH: begin
          if (last_tap) begin
            krn_rd <= 1'b0;
            img_rd <= 1'b0;
          end else begin
            tap      <= tap + 1'b1;
            krn_addr <= krn_addr + 1'b1;
            if (col_last) begin
              // Step to the next row by adding the pitch; addresses wrap silently.
              col      <= '0;
              row_base <= row_base + ADDR_B_W'(IMG_WIDTH);
              img_addr <= row_base + ADDR_B_W'(IMG_WIDTH);
            end else begin
              col      <= col + 1'b1;
              img_addr <= img_addr + 1'b1;
            end
          end
        end
        DRAIN: begin
          out_pix_q <= pix_val;
          ack_q     <= 1'b1;
        end
        ACK: begin
          if (!ctrl.en) begin
            ack_q  <= 1'b0;
            busy_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_window_mac.sv
// tb/tb_conv_window_mac.sv - randomized self-checking bench for conv_window_mac
module tb_conv_window_mac;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic               krn_rd, img_rd;
  logic [7:0]         krn_addr;
  logic [12:0]        img_addr;
  logic signed [15:0] krn_data, img_data;

  logic signed [15:0] krn_mem [256];
  logic signed [15:0] img_mem [8192];

  int total = 0;
  int bad   = 0;

  conv_window_mac_if #(.ADDR_A_W(4), .ADDR_B_W(13), .ACC_W(32)) cif ();

  conv_window_mac dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ctrl     (cif),
    .krn_rd   (krn_rd),
    .krn_addr (krn_addr),
    .krn_data (krn_data),
    .img_rd   (img_rd),
    .img_addr (img_addr),
    .img_data (img_data)
  );

  // Synchronous memories: word appears the cycle after the strobe.
  always @(posedge clk) begin
    if (krn_rd) krn_data <= krn_mem[krn_addr];
    if (img_rd) img_data <= img_mem[img_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int kaddr(input int a, input int t);
    return (a * 9 + t) % 256;
  endfunction

  function automatic int iaddr(input int b, input int t);
    return (b + (t / 3) * 64 + (t % 3)) % 8192;
  endfunction

  // Reference: plain sum over the window with 32-bit wrap, optional clamp.
  function automatic int ref_pix(input int a, input int b);
    int s = 0;
    for (int t = 0; t < 9; t++)
      s = s + int'(krn_mem[kaddr(a, t)]) * int'(img_mem[iaddr(b, t)]);
`ifdef CONV_RELU_EN
    if (s < 0) s = 0;
`endif
    return s;
  endfunction

  // One full request. extra: cycles en stays high after ack; pulse: en high for
  // the accept edge only.
  task automatic do_req(input int a, input int b, input int extra, input bit pulse);
    int exp_pix;
    exp_pix = ref_pix(a, b);
    @(negedge clk);
    cif.en = 1'b1;
    cif.base_addrA = 4'(a);
    cif.base_addrB = 13'(b);
    @(posedge clk);
    @(negedge clk);
    // Changed inputs after accept must be ignored.
    cif.base_addrA = 4'($urandom);
    cif.base_addrB = 13'($urandom);
    if (pulse) cif.en = 1'b0;
    for (int t = 0; t < 9; t++) begin
      if (t > 0) @(negedge clk);
      chk("krn_rd", 32'(krn_rd), 32'd1);
      chk("img_rd", 32'(img_rd), 32'd1);
      chk("krn_addr", 32'(krn_addr), 32'(kaddr(a, t)));
      chk("img_addr", 32'(img_addr), 32'(iaddr(b, t)));
      chk("busy_fetch", 32'(cif.busy), 32'd1);
      chk("ack_fetch", 32'(cif.ack), 32'd0);
    end
    @(negedge clk);
    chk("rd_drain", 32'({krn_rd, img_rd}), 32'd0);
    chk("ack_drain", 32'(cif.ack), 32'd0);
    @(negedge clk);
    chk("ack_rise", 32'(cif.ack), 32'd1);
    chk("out_pix", cif.out_pix, 32'(exp_pix));
    if (!pulse) begin
      for (int i = 0; i < extra; i++) begin
        @(negedge clk);
        chk("ack_hold", 32'(cif.ack), 32'd1);
        chk("pix_hold", cif.out_pix, 32'(exp_pix));
      end
      cif.en = 1'b0;
    end
    @(negedge clk);
    chk("ack_fall", 32'(cif.ack), 32'd0);
    chk("busy_fall", 32'(cif.busy), 32'd0);
    chk("pix_keep", cif.out_pix, 32'(exp_pix));
  endtask

  initial begin
    int pix_neg;
    cif.en = 1'b0;
    cif.base_addrA = '0;
    cif.base_addrB = '0;
    for (int i = 0; i < 256; i++)  krn_mem[i] = 16'($urandom);
    for (int i = 0; i < 8192; i++) img_mem[i] = 16'($urandom);

    // Kernel 2 all ones, window at 100 = 1..9.
    for (int t = 0; t < 9; t++) begin
      krn_mem[kaddr(2, t)] = 16'sd1;
      img_mem[iaddr(100, t)] = 16'(t + 1);
    end
    // Kernel 5 all -2, window at 2000 all 3000.
    for (int t = 0; t < 9; t++) begin
      krn_mem[kaddr(5, t)] = -16'sd2;
      img_mem[iaddr(2000, t)] = 16'sd3000;
    end
    // Kernel 1 identity centre tap, window at 4000 centre = 7.
    for (int t = 0; t < 9; t++) krn_mem[kaddr(1, t)] = (t == 4) ? 16'sd1 : 16'sd0;
    img_mem[iaddr(4000, 4)] = 16'sd7;

    repeat (3) @(negedge clk);
    chk("rst_ack", 32'(cif.ack), 32'd0);
    chk("rst_busy", 32'(cif.busy), 32'd0);
    chk("rst_pix", cif.out_pix, 32'd0);
    chk("rst_rd", 32'({krn_rd, img_rd}), 32'd0);
    chk("rst_addr", 32'({krn_addr, img_addr}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_req(2, 100, 0, 1'b0);
    chk("pix45", cif.out_pix, 32'd45);

    do_req(5, 2000, 5, 1'b0);
`ifdef CONV_RELU_EN
    pix_neg = 0;
`else
    pix_neg = -54000;
`endif
    chk("pix_neg", cif.out_pix, 32'(pix_neg));

    do_req(7, 8190, 2, 1'b0);
    do_req(3, 8100, 0, 1'b1);

    for (int n = 0; n < 8; n++)
      do_req(int'($urandom_range(0, 15)), int'($urandom_range(0, 8191)),
             int'($urandom_range(0, 3)), 1'($urandom));

    // Reset in FETCH tap 4: everything clears at once, no ack.
    @(negedge clk);
    cif.en = 1'b1;
    cif.base_addrA = 4'd9;
    cif.base_addrB = 13'd500;
    @(posedge clk);
    repeat (5) @(negedge clk);
    chk("tap4_addr", 32'(img_addr), 32'(iaddr(500, 4)));
    rst_n = 1'b0;
    #1;
    chk("arst_ack", 32'(cif.ack), 32'd0);
    chk("arst_busy", 32'(cif.busy), 32'd0);
    chk("arst_pix", cif.out_pix, 32'd0);
    chk("arst_rd", 32'({krn_rd, img_rd}), 32'd0);
    chk("arst_addr", 32'({krn_addr, img_addr}), 32'd0);
    cif.en = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("arst_noack", 32'(cif.ack), 32'd0);
    end
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      chk("post_rst_noack", 32'(cif.ack), 32'd0);
    end

    do_req(1, 4000, 1, 1'b0);
    chk("pix7", cif.out_pix, 32'd7);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
